// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between port0 (vector LSU) and port1 (host/DMA loader),
// registers the RAM-side signals and routes read data back by tag. Optional macro: ARB_FIXED_PRIO_EN.
module ram_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 256,
    parameter int BE_W       = DATA_W / 8,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_rden,
    input  logic              p0_wren,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [BE_W-1:0]   p0_byteena,
    input  logic [DATA_W-1:0] p0_writeData,
    output logic              p0_ready,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_readData,

    input  logic              p1_rden,
    input  logic              p1_wren,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [BE_W-1:0]   p1_byteena,
    input  logic [DATA_W-1:0] p1_writeData,
    output logic              p1_ready,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_readData,

    output logic [ADDR_W-1:0] address_RAM,
    output logic [BE_W-1:0]   byteena_RAM,
    output logic [DATA_W-1:0] writeData_RAM,
    output logic              rden_RAM,
    output logic              wren_RAM,
    input  logic [DATA_W-1:0] readData_RAM
);

    // Handshake: pN_rden/pN_wren are levels whose fields stay stable until pN_ready; the cycle
    // pN_ready is high is the accept. A request dropped before its ready cycle issues nothing.

    logic              p0_req;
    logic              p1_req;
    logic              gnt0;
    logic              gnt1;
    logic              accept;

    logic              sel_rd;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wd;

    logic              rden_q, rden_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              issue_port_q, issue_port_d;

    logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LATENCY-1:0] tag_port_q, tag_port_d;

    assign p0_req = p0_rden | p0_wren;
    assign p1_req = p1_rden | p1_wren;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = p0_req & ~reset;
        gnt1 = p1_req & ~p0_req & ~reset;
    end
`else
    // last_gnt_q = 1 means port1 was granted most recently, so port0 wins the next conflict.
    logic last_gnt_q, last_gnt_d;

    always_comb begin
        gnt0       = p0_req & (~p1_req | last_gnt_q) & ~reset;
        gnt1       = p1_req & (~p0_req | ~last_gnt_q) & ~reset;
        last_gnt_d = last_gnt_q;
        if (gnt0) begin
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    assign p0_ready = gnt0;
    assign p1_ready = gnt1;
    assign accept   = gnt0 | gnt1;

    // A write takes precedence over a simultaneous read on the same port.
    always_comb begin
        sel_wr   = gnt1 ? p1_wren      : p0_wren;
        sel_rd   = (gnt1 ? p1_rden     : p0_rden) & ~sel_wr;
        sel_addr = gnt1 ? p1_address   : p0_address;
        sel_be   = gnt1 ? p1_byteena   : p0_byteena;
        sel_wd   = gnt1 ? p1_writeData : p0_writeData;
    end

    always_comb begin
        rden_d       = accept & sel_rd;
        wren_d       = accept & sel_wr;
        addr_d       = addr_q;
        be_d         = be_q;
        wd_d         = wd_q;
        issue_port_d = issue_port_q;
        if (accept) begin
            addr_d       = sel_addr;
            be_d         = sel_wr ? sel_be : '0;
            issue_port_d = gnt1;
            if (sel_wr) begin
                wd_d = sel_wd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rden_q       <= 1'b0;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wd_q         <= '0;
            issue_port_q <= 1'b0;
        end else begin
            rden_q       <= rden_d;
            wren_q       <= wren_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wd_q         <= wd_d;
            issue_port_q <= issue_port_d;
        end
    end

    assign address_RAM   = addr_q;
    assign byteena_RAM   = be_q;
    assign writeData_RAM = wd_q;
    assign rden_RAM      = rden_q;
    assign wren_RAM      = wren_q;

    // Tag enters when the read is on the RAM pins; the last stage lines up with readData_RAM.
    always_comb begin
        tag_vld_d     = tag_vld_q;
        tag_port_d    = tag_port_q;
        tag_vld_d[0]  = rden_q;
        tag_port_d[0] = issue_port_q;
        for (int k = 1; k < RD_LATENCY; k++) begin
            tag_vld_d[k]  = tag_vld_q[k-1];
            tag_port_d[k] = tag_port_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld_q  <= '0;
            tag_port_q <= '0;
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
        end
    end

    assign p0_rvalid   = tag_vld_q[RD_LATENCY-1] & ~tag_port_q[RD_LATENCY-1] & ~reset;
    assign p1_rvalid   = tag_vld_q[RD_LATENCY-1] &  tag_port_q[RD_LATENCY-1] & ~reset;
    assign p0_readData = readData_RAM;
    assign p1_readData = readData_RAM;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: three instances (RD_LATENCY 2, 1, 4) driven in parallel,
// each with its own RAM model, a read-return scoreboard and a round-robin grant model.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 256;
    localparam int BE_W   = 32;
    localparam int NI     = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic              p0_rden, p0_wren, p1_rden, p1_wren;
    logic [ADDR_W-1:0] p0_address, p1_address;
    logic [BE_W-1:0]   p0_byteena, p1_byteena;
    logic [DATA_W-1:0] p0_writeData, p1_writeData;

    logic              rdy0 [NI];
    logic              rdy1 [NI];
    logic              rv0 [NI];
    logic              rv1 [NI];
    logic              rden_o [NI];
    logic              wren_o [NI];
    logic [DATA_W-1:0] rd0 [NI];
    logic [DATA_W-1:0] rd1 [NI];
    logic [DATA_W-1:0] wd_o [NI];
    logic [DATA_W-1:0] rdram [NI];
    logic [ADDR_W-1:0] addr_o [NI];
    logic [BE_W-1:0]   be_o [NI];

    logic [DATA_W-1:0] mem [NI][DEPTH];
    logic [DATA_W-1:0] pipe [NI][4];
    logic [DATA_W-1:0] shadow [DEPTH];
    logic [DATA_W+16:0] exp_q [NI][$];
    logic [DATA_W+16:0] e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar j = 0; j < NI; j++) begin : g_dut
        localparam int L = (j == 0) ? 2 : (j == 1) ? 1 : 4;
        ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .RD_LATENCY(L)) u_dut (
            .clk(clk), .reset(reset),
            .p0_rden(p0_rden), .p0_wren(p0_wren), .p0_address(p0_address),
            .p0_byteena(p0_byteena), .p0_writeData(p0_writeData),
            .p0_ready(rdy0[j]), .p0_rvalid(rv0[j]), .p0_readData(rd0[j]),
            .p1_rden(p1_rden), .p1_wren(p1_wren), .p1_address(p1_address),
            .p1_byteena(p1_byteena), .p1_writeData(p1_writeData),
            .p1_ready(rdy1[j]), .p1_rvalid(rv1[j]), .p1_readData(rd1[j]),
            .address_RAM(addr_o[j]), .byteena_RAM(be_o[j]), .writeData_RAM(wd_o[j]),
            .rden_RAM(rden_o[j]), .wren_RAM(wren_o[j]), .readData_RAM(rdram[j])
        );
        assign rdram[j] = pipe[j][L-1];
    end

    function automatic int lat_of(input int j);
        case (j)
            0: return 2;
            1: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] pat(input int a);
        logic [31:0] s;
        s = 32'(a) ^ 32'hC35A_0000;
        return {8{s}};
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] nw,
                                                input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < BE_W; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // RAM models: read data appears RD_LATENCY cycles after rden_RAM, byte-enabled writes.
    always @(posedge clk) begin
        for (int j = 0; j < NI; j++) begin
            for (int k = 3; k > 0; k--) pipe[j][k] <= pipe[j][k-1];
            pipe[j][0] <= rden_o[j] ? mem[j][addr_o[j]] : '0;
            if (wren_o[j]) mem[j][addr_o[j]] <= merge(mem[j][addr_o[j]], wd_o[j], be_o[j]);
        end
    end

    // Scoreboard: expected reads pushed on accept, popped when (or when due) rvalid fires.
    always @(negedge clk) begin
        for (int j = 0; j < NI; j++) begin
            if (reset) begin
                chk($sformatf("rst_rvalid_i%0d", j), {rv1[j], rv0[j]}, 2'b00);
                exp_q[j].delete();
            end else begin
                if (rv0[j] || rv1[j] ||
                    (exp_q[j].size() != 0 && int'(exp_q[j][0][DATA_W+16:DATA_W+1]) <= cyc)) begin
                    if (exp_q[j].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rv_unexpected_i%0d: got rvalid %b%b want none", j, rv1[j], rv0[j]);
                    end else begin
                        e = exp_q[j].pop_front();
                        chk($sformatf("rv_port_i%0d", j), {rv1[j], rv0[j]}, e[DATA_W] ? 2'b10 : 2'b01);
                        chk($sformatf("rv_cycle_i%0d", j), cyc, int'(e[DATA_W+16:DATA_W+1]));
                        chk($sformatf("rv_data_i%0d", j), e[DATA_W] ? rd1[j] : rd0[j], e[DATA_W-1:0]);
                    end
                end
                if (rdy0[j] && p0_rden && !p0_wren)
                    exp_q[j].push_back({16'(cyc + 1 + lat_of(j)), 1'b0, shadow[p0_address]});
                if (rdy1[j] && p1_rden && !p1_wren)
                    exp_q[j].push_back({16'(cyc + 1 + lat_of(j)), 1'b1, shadow[p1_address]});
            end
        end
        if (!reset) begin
            if (rdy0[0] && p0_wren) shadow[p0_address] = merge(shadow[p0_address], p0_writeData, p0_byteena);
            if (rdy1[0] && p1_wren) shadow[p1_address] = merge(shadow[p1_address], p1_writeData, p1_byteena);
        end
    end

    typedef struct {
        logic              r0, w0, r1, w1;
        logic [ADDR_W-1:0] a0, a1;
        logic [BE_W-1:0]   be0, be1;
        logic [DATA_W-1:0] d0, d1;
        logic              g0, g1;
    } vec_t;

    function automatic vec_t mk(input logic r0, w0, input logic [ADDR_W-1:0] a0,
                                input logic [BE_W-1:0] be0, input logic [DATA_W-1:0] d0,
                                input logic r1, w1, input logic [ADDR_W-1:0] a1,
                                input logic [BE_W-1:0] be1, input logic [DATA_W-1:0] d1,
                                input logic g0, g1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.be0 = be0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic idle();
        p0_rden = 0; p0_wren = 0; p0_address = '0; p0_byteena = '0; p0_writeData = '0;
        p1_rden = 0; p1_wren = 0; p1_address = '0; p1_byteena = '0; p1_writeData = '0;
    endtask

    task automatic check_ram(input string tag, input logic e_rd, input logic e_wr,
                             input logic [ADDR_W-1:0] e_a, input logic [BE_W-1:0] e_be,
                             input logic [DATA_W-1:0] e_wd, input logic chk_wd);
        for (int j = 0; j < NI; j++) begin
            chk($sformatf("%s_rden_i%0d", tag, j), rden_o[j], e_rd);
            chk($sformatf("%s_wren_i%0d", tag, j), wren_o[j], e_wr);
            chk($sformatf("%s_addr_i%0d", tag, j), addr_o[j], e_a);
            chk($sformatf("%s_be_i%0d", tag, j), be_o[j], e_be);
            if (chk_wd) chk($sformatf("%s_wd_i%0d", tag, j), wd_o[j], e_wd);
        end
    endtask

    task automatic check_ready(input string tag, input logic e0, input logic e1);
        for (int j = 0; j < NI; j++) begin
            chk($sformatf("%s_ready0_i%0d", tag, j), rdy0[j], e0);
            chk($sformatf("%s_ready1_i%0d", tag, j), rdy1[j], e1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1; p0_rden = 1; p0_address = 14'h0123; p1_wren = 1; p1_address = 14'h0456; p1_byteena = '1;
        @(negedge clk);
        check_ready("in_reset", 1'b0, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_ram("reset", 1'b0, 1'b0, '0, '0, '0, 1'b1);
        @(posedge clk); #1;
        reset = 0;
        idle();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            idle();
        end
    endtask

    task automatic gen_req(output logic r, output logic w, output logic [ADDR_W-1:0] a,
                           output logic [BE_W-1:0] be, output logic [DATA_W-1:0] d);
        int k;
        k = $urandom_range(0, 3);
        r = (k != 1);
        w = (k == 1) || (k == 2);
        a = ADDR_W'($urandom_range(0, 15));
        be = $urandom();
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom();
    endtask

    localparam logic [DATA_W-1:0] D1 = {32{8'h3C}};
    localparam logic [DATA_W-1:0] D2 = {8{32'hDEADBEEF}};
    localparam logic [DATA_W-1:0] D3 = {16{16'h1234}};
    localparam logic [DATA_W-1:0] D4 = {4{64'h0123456789ABCDEF}};
    localparam logic [DATA_W-1:0] DA5 = {32{8'hA5}};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [13];
        vec_t v;
        logic e_rd, e_wr, have_prev, gw;
        logic [ADDR_W-1:0] e_a;
        logic [BE_W-1:0] e_be;
        logic [DATA_W-1:0] e_wd;
        logic [ADDR_W-1:0] a0n, a1n;
        logic pend0, pend1, lg, m0, m1;
        logic r, w;
        logic [ADDR_W-1:0] a;
        logic [BE_W-1:0] be;
        logic [DATA_W-1:0] d;

        reset = 1;
        idle();
        for (int j = 0; j < NI; j++) begin
            for (int k = 0; k < 4; k++) pipe[j][k] = '0;
            for (int i = 0; i < DEPTH; i++) mem[j][i] = pat(i);
        end
        for (int i = 0; i < DEPTH; i++) shadow[i] = pat(i);

        //             r0 w0 a0        be0           d0   r1 w1 a1        be1           d1   g0 g1
        vecs[0]  = mk(1, 0, 14'h0010, '0,           '0,  0, 0, 14'h0000, '0,           '0,  1, 0);
        vecs[1]  = mk(1, 0, 14'h0011, '0,           '0,  1, 0, 14'h0020, '0,           '0,  0, 1);
        vecs[2]  = mk(1, 0, 14'h0011, '0,           '0,  1, 0, 14'h0021, '0,           '0,  1, 0);
        vecs[3]  = mk(1, 0, 14'h0012, '0,           '0,  1, 0, 14'h0021, '0,           '0,  0, 1);
        vecs[4]  = mk(0, 0, 14'h0000, '0,           '0,  0, 1, 14'h0030, 32'hFFFFFFFF, D1,  0, 1);
        vecs[5]  = mk(1, 1, 14'h0031, 32'h0000000F, D2,  0, 0, 14'h0000, '0,           '0,  1, 0);
        vecs[6]  = mk(0, 0, 14'h0000, '0,           '0,  0, 0, 14'h0000, '0,           '0,  0, 0);
        vecs[7]  = mk(0, 0, 14'h0000, '0,           '0,  1, 0, 14'h0030, '0,           '0,  0, 1);
        vecs[8]  = mk(0, 1, 14'h0040, 32'hF0F0F0F0, D3,  0, 1, 14'h0041, 32'hFFFFFFFF, D4,  1, 0);
        vecs[9]  = mk(0, 0, 14'h0000, '0,           '0,  0, 1, 14'h0041, 32'hFFFFFFFF, D4,  0, 1);
        vecs[10] = mk(1, 0, 14'h0031, '0,           '0,  0, 0, 14'h0000, '0,           '0,  1, 0);
        vecs[11] = mk(1, 0, 14'h0040, '0,           '0,  1, 0, 14'h3FFF, '0,           '0,  0, 1);
        vecs[12] = mk(1, 0, 14'h0040, '0,           '0,  0, 0, 14'h0000, '0,           '0,  1, 0);

        do_reset();

        // Table: grants and the registered RAM access one cycle later.
        have_prev = 0; e_rd = 0; e_wr = 0; e_a = '0; e_be = '0; e_wd = '0;
        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            @(posedge clk); #1;
            p0_rden = v.r0; p0_wren = v.w0; p0_address = v.a0; p0_byteena = v.be0; p0_writeData = v.d0;
            p1_rden = v.r1; p1_wren = v.w1; p1_address = v.a1; p1_byteena = v.be1; p1_writeData = v.d1;
            @(negedge clk);
            if (have_prev) check_ram($sformatf("v%0d_ram", i - 1), e_rd, e_wr, e_a, e_be, e_wd, e_wr);
            check_ready($sformatf("v%0d", i), v.g0, v.g1);
            if (v.g0 || v.g1) begin
                gw   = v.g1 ? v.w1 : v.w0;
                e_rd = (v.g1 ? v.r1 : v.r0) & ~gw;
                e_wr = gw;
                e_a  = v.g1 ? v.a1 : v.a0;
                e_be = gw ? (v.g1 ? v.be1 : v.be0) : '0;
                if (gw) e_wd = v.g1 ? v.d1 : v.d0;
            end else begin
                e_rd = 0;
                e_wr = 0;
            end
            have_prev = 1;
        end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check_ram("v12_ram", e_rd, e_wr, e_a, e_be, e_wd, e_wr);
        drain(6);

        // Write then read of the top address on port1.
        @(posedge clk); #1;
        p1_wren = 1; p1_address = 14'h3FFF; p1_byteena = '1; p1_writeData = DA5;
        @(negedge clk);
        check_ready("wr3fff", 1'b0, 1'b1);
        @(posedge clk); #1;
        p1_wren = 0; p1_rden = 1;
        @(negedge clk);
        check_ready("rd3fff", 1'b0, 1'b1);
        check_ram("wr3fff_ram", 1'b0, 1'b1, 14'h3FFF, 32'hFFFFFFFF, DA5, 1'b1);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check_ram("rd3fff_ram", 1'b1, 1'b0, 14'h3FFF, '0, '0, 1'b0);
        drain(6);

        // Conflict from reset: both ports read continuously, grants alternate starting with port0.
        do_reset();
        a0n = 14'h0100; a1n = 14'h0200;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            p0_rden = 1; p0_address = a0n; p1_rden = 1; p1_address = a1n;
            @(negedge clk);
            check_ready($sformatf("rr%0d", k), (k % 2) == 0, (k % 2) == 1);
            if ((k % 2) == 0) a0n = a0n + 1;
            else a1n = a1n + 1;
        end
        drain(7);

        // Reset while a read is in flight: no return, RAM side cleared.
        @(posedge clk); #1;
        p0_rden = 1; p0_address = 14'h0055;
        @(negedge clk);
        check_ready("pre_rst", 1'b1, 1'b0);
        @(posedge clk); #1;
        idle();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check_ram("midrst", 1'b0, 1'b0, '0, '0, '0, 1'b1);
        drain(7);

        // Back-to-back lone reads: every instance returns each at accept+1+RD_LATENCY.
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            p0_rden = 1; p0_address = ADDR_W'($urandom_range(0, DEPTH - 1));
            @(negedge clk);
            check_ready($sformatf("b2b%0d", k), 1'b1, 1'b0);
        end
        drain(7);

        // Random traffic against a round-robin grant model, requests held until ready.
        do_reset();
        lg = 1; pend0 = 0; pend1 = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (pend0 && $urandom_range(0, 15) == 0) pend0 = 0;
            if (pend1 && $urandom_range(0, 15) == 0) pend1 = 0;
            if (!pend0 && $urandom_range(0, 2) != 0) begin
                gen_req(r, w, a, be, d);
                pend0 = 1; p0_rden = r; p0_wren = w; p0_address = a; p0_byteena = be; p0_writeData = d;
            end
            if (!pend1 && $urandom_range(0, 2) != 0) begin
                gen_req(r, w, a, be, d);
                pend1 = 1; p1_rden = r; p1_wren = w; p1_address = a; p1_byteena = be; p1_writeData = d;
            end
            if (!pend0) begin p0_rden = 0; p0_wren = 0; end
            if (!pend1) begin p1_rden = 0; p1_wren = 0; end
            @(negedge clk);
            m0 = pend0 & (~pend1 | lg);
            m1 = pend1 & (~pend0 | ~lg);
            check_ready($sformatf("rnd%0d", c), m0, m1);
            if (m0) begin lg = 0; pend0 = 0; end
            else if (m1) begin lg = 1; pend1 = 0; end
        end
        drain(8);
        @(negedge clk);
        for (int j = 0; j < NI; j++) chk($sformatf("drained_i%0d", j), exp_q[j].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
